// File: rtl/cromossomo_serial_loader_if.sv
// Byte-stream and chromosome bundle between the serial source, the loader and the phenotype stage.
// The master side drives the byte stream and control pulses; the slave side is the loader.
interface cromossomo_serial_loader_if #(
  parameter int CHROM_BITS = 468,
  parameter int BYTE_W     = 8
);
  logic                  start;
  logic                  abort;
  logic [BYTE_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CHROM_BITS-1:0] cromossomo;
  logic                  chrom_valid;
  logic                  busy;
  logic                  load_done;
  logic                  pad_err;

  modport master (
    output start, abort, in_data, in_valid,
    input  in_ready, cromossomo, chrom_valid, busy, load_done, pad_err
  );

  modport slave (
    input  start, abort, in_data, in_valid,
    output in_ready, cromossomo, chrom_valid, busy, load_done, pad_err
  );
endinterface

// File: rtl/cromossomo_serial_loader.sv
// Assembles a chromosome byte-by-byte into a shadow register and commits it in one edge,
// so the phenotype mapper never sees a half-loaded chromosome.
module cromossomo_serial_loader #(
  parameter int CHROM_BITS = 468,
  parameter int BYTE_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  cromossomo_serial_loader_if.slave  bus
);

  localparam int NUM_BYTES = (CHROM_BITS + BYTE_W - 1) / BYTE_W;
  localparam int SHADOW_W  = NUM_BYTES * BYTE_W;
  localparam int PAD_BITS  = SHADOW_W - CHROM_BITS;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]     shadow_q [NUM_BYTES];
  logic [SHADOW_W-1:0]   shadow_flat;
  logic [CHROM_BITS-1:0] crom_q;
  logic                  chrom_valid_q;
  logic                  in_ready_q;
  logic                  load_done_q;
  logic                  pad_err_q;

  logic                  beat;
  logic                  wr_en;
  logic                  commit_ok;
  logic                  commit_bad;
  logic                  pad_nz;

  // in_ready_q is only ever high while in LOAD, so beats cannot occur in other states.
  assign beat = bus.in_valid & in_ready_q;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_shadow
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q[gi] <= '0;
        end else if (wr_en && (byte_cnt_q == CNT_W'(gi))) begin
          shadow_q[gi] <= bus.in_data;
        end
      end
      assign shadow_flat[gi*BYTE_W +: BYTE_W] = shadow_q[gi];
    end
  endgenerate

  generate
    if (PAD_BITS > 0) begin : g_pad
      assign pad_nz = |shadow_flat[SHADOW_W-1:CHROM_BITS];
    end else begin : g_nopad
      assign pad_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wr_en      = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
        end
      end
      S_LOAD: begin
        // abort beats start beats a data beat; a restart drops the same-cycle byte.
        if (bus.abort) begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
        end else if (bus.start) begin
          byte_cnt_d = '0;
        end else if (beat) begin
          wr_en = 1'b1;
          if (byte_cnt_q == LAST_CNT) begin
            state_d    = S_COMMIT;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (pad_nz) commit_bad = 1'b1;
        else        commit_ok  = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        byte_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      in_ready_q    <= 1'b0;
      load_done_q   <= 1'b0;
      pad_err_q     <= 1'b0;
      chrom_valid_q <= 1'b0;
      crom_q        <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      in_ready_q  <= (state_d == S_LOAD);
      load_done_q <= commit_ok;
      pad_err_q   <= commit_bad;
      if (commit_ok) begin
        crom_q        <= shadow_flat[CHROM_BITS-1:0];
        chrom_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.cromossomo  = crom_q;
  assign bus.chrom_valid = chrom_valid_q;
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_COMMIT);
  assign bus.load_done   = load_done_q;
  assign bus.pad_err     = pad_err_q;

endmodule

// File: tb/tb_cromossomo_serial_loader.sv
// Directed and randomized byte streams against a byte-list chromosome model.
module tb_cromossomo_serial_loader;
  localparam int CB = 468;
  localparam int NB = 59;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cromossomo_serial_loader_if #(.CHROM_BITS(CB), .BYTE_W(8)) bus ();

  cromossomo_serial_loader #(.CHROM_BITS(CB), .BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]    stim [NB];
  logic [CB-1:0] exp_crom;
  logic          exp_valid;

  task automatic check(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Offer stim[first .. first+n-1] with random idle gaps; a byte moves on only on valid&ready.
  task automatic feed(input int first, input int n, input int gap_pct, input string tag);
    int   idx = first;
    int   budget = 0;
    int   not_rdy = 0;
    logic rdy;
    bit   v;
    while (idx < first + n && budget < 3000) begin
      rdy = bus.in_ready;
      if (rdy !== 1'b1) not_rdy++;
      v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = v ? stim[idx] : 8'($urandom);
      tick();
      if (v && rdy === 1'b1) idx++;
      budget++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_feed_done"}, (budget < 3000), 1);
    check({tag, "_ready_in_load"}, not_rdy, 0);
  endtask

  // Chromosome = byte list laid little-endian; the top 4 bits of the last byte are padding.
  task automatic model_commit(output bit ok);
    logic [NB*8-1:0] tmp;
    for (int k = 0; k < NB; k++) tmp[8*k +: 8] = stim[k];
    ok = (tmp[NB*8-1:CB] == '0);
    if (ok) begin
      exp_crom  = tmp[CB-1:0];
      exp_valid = 1'b1;
    end
  endtask

  // Called in the COMMIT cycle, right after the final byte was accepted.
  task automatic finish_commit(input string tag);
    bit ok;
    check({tag, "_commit_ready"}, bus.in_ready, 0);
    check({tag, "_commit_busy"}, bus.busy, 1);
    check({tag, "_commit_early_done"}, bus.load_done, 0);
    check({tag, "_crom_held"}, bus.cromossomo, exp_crom);
    model_commit(ok);
    tick();
    $display("load %s: pad_ok=%0d load_done=%0d pad_err=%0d", tag, ok, bus.load_done, bus.pad_err);
    check({tag, "_load_done"}, bus.load_done, ok);
    check({tag, "_pad_err"}, bus.pad_err, !ok);
    check({tag, "_crom"}, bus.cromossomo, exp_crom);
    check({tag, "_chrom_valid"}, bus.chrom_valid, exp_valid);
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_ready_after"}, bus.in_ready, 0);
    tick();
    check({tag, "_pulse_end"}, {bus.load_done, bus.pad_err}, 0);
  endtask

  task automatic full_load(input string tag, input int gap_pct);
    check({tag, "_idle_ready"}, bus.in_ready, 0);
    do_start();
    feed(0, NB, gap_pct, tag);
    finish_commit(tag);
  endtask

  initial begin
    exp_crom     = '0;
    exp_valid    = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    rst          = 1'b1;
    tick(); tick(); tick();
    check("rst_crom", bus.cromossomo, 0);
    check("rst_outs", {bus.in_ready, bus.busy, bus.chrom_valid, bus.load_done, bus.pad_err}, 0);
    rst = 1'b0;
    // in_valid in IDLE must be ignored
    repeat (4) tick();
    check("idle_ignore", {bus.in_ready, bus.busy, bus.load_done}, 0);
    bus.in_valid = 1'b0;

    // 1: counting bytes, back-to-back
    for (int k = 0; k < NB; k++) stim[k] = 8'(k);
    stim[NB-1] = 8'h0A;
    full_load("t1", 0);
    check("t1_byte0", bus.cromossomo[7:0], 8'h00);
    check("t1_byte1", bus.cromossomo[15:8], 8'h01);
    check("t1_top", bus.cromossomo[467:464], 4'hA);

    // 2: 0xA5 pattern with ~50% gaps
    for (int k = 0; k < NB; k++) stim[k] = 8'hA5;
    stim[NB-1] = 8'h05;
    full_load("t2", 50);

    // 3: padding bit set -> rejected
    stim[NB-1] = 8'h15;
    full_load("t3", 20);

    // 4: abort after 30 bytes, then all-ones load
    for (int k = 0; k < NB; k++) stim[k] = 8'h3C;
    do_start();
    feed(0, 30, 0, "t4a");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4_abort_state", {bus.busy, bus.in_ready, bus.load_done, bus.pad_err}, 0);
    check("t4_abort_crom", bus.cromossomo, exp_crom);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check("t4_idle_after_abort", {bus.busy, bus.in_ready}, 0);
    for (int k = 0; k < NB; k++) stim[k] = 8'hFF;
    stim[NB-1] = 8'h0F;
    full_load("t4", 0);
    check("t4_all_ones", bus.cromossomo, {CB{1'b1}});

    // 5: restart after 20 bytes with a same-cycle byte that must be dropped
    for (int k = 0; k < NB; k++) stim[k] = 8'h11;
    do_start();
    feed(0, 20, 0, "t5a");
    for (int k = 0; k < NB; k++) stim[k] = 8'($urandom);
    stim[NB-1][7:4] = 4'h0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    feed(0, NB - 1, 30, "t5b");
    repeat (4) tick();
    check("t5_no_early_commit", {bus.busy, bus.load_done, bus.pad_err}, 3'b100);
    check("t5_crom_held", bus.cromossomo, exp_crom);
    feed(NB - 1, 1, 0, "t5c");
    finish_commit("t5");

    // 6: asynchronous reset mid-load, between clock edges
    do_start();
    feed(0, 25, 0, "t6a");
    #2 rst = 1'b1;
    #1;
    check("t6_async_crom", bus.cromossomo, 0);
    check("t6_async_outs", {bus.in_ready, bus.busy, bus.chrom_valid, bus.load_done, bus.pad_err}, 0);
    exp_crom  = '0;
    exp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < NB; k++) stim[k] = 8'($urandom);
    stim[NB-1][7:4] = 4'h0;
    full_load("t6", 40);

    // 7: random chromosomes, padding alternately clean and dirty
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NB; k++) stim[k] = 8'($urandom);
      if (i % 2 == 0) stim[NB-1][7:4] = 4'h0;
      else            stim[NB-1][7:4] = 4'($urandom_range(15, 1));
      full_load($sformatf("t7_%0d", i), $urandom_range(60));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
